y86_bus_mem: RTL and testbench
==============================

# y86_bus_mem

Byte-addressed memory responder for the y86 sequential core's bus (`bus_A`/`bus_RE`/`bus_WE`/`bus_in`/`bus_out`).
- Serves zero-wait-state 32-bit little-endian reads and writes at any byte alignment.
- Provides a byte preload port and a whole-memory clear engine.
- Sits opposite the core in every simulation and FPGA top, replacing ad-hoc behavioural memories.

## Interface
- `ADDR_W`, default 12: byte address width; DEPTH = 2**ADDR_W bytes; DEPTH multiple of 4, ≥ 8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus_A` in 32: byte address from the core.
- `bus_RE` in 1: read strobe.
- `bus_WE` in 1: write strobe.
- `bus_out` in 32: core write data.
- `bus_in` out 32: read data returned to the core.
- `ld_valid` in 1: preload byte offered.
- `ld_ready` out 1: preload byte accepted this cycle.
- `ld_addr` in ADDR_W: preload byte address.
- `ld_data` in 8: preload byte.
- `clr_start` in 1: single-cycle request to zero the whole array.
- `busy` out 1: clear in progress.
- `rd_count` out 16: saturating count of accepted reads.
- `wr_count` out 16: saturating count of accepted writes.
- `err` out 1: sticky error flag.
- `err_code` out 2: cause of the first error; 0 none, 1 range, 2 RE+WE collision, 3 access while busy.
- `err_addr` out 32: `bus_A` of the first error.
- `err_clr` in 1: clears `err`, `err_code` and `err_addr`.

## Operation
- Byte layout: bytes a..a+3 map to `bus_in[7:0]`..`[31:24]`. Writes are the same, byte a taking `bus_out[7:0]`.
- Reads are combinational. `bus_in` = word at `bus_A` while `bus_RE` is high and the access is valid; otherwise 0.
- Writes commit all 4 bytes on the rising edge that samples `bus_WE` high. A read in the same cycle sees the pre-write data.
- RE and WE both high: set err code 2. The write still commits and the read returns old data.
- Preload:
  - `ld_ready` = !busy && !bus_WE; core writes take priority.
  - A byte is written on edges where `ld_valid` && `ld_ready`.
  - Preloads are not counted.
- Clear FSM, states IDLE → CLEAR → IDLE:
  - `clr_start` is honoured in IDLE only; it is ignored while busy.
  - CLEAR writes zero to one aligned word per cycle, index 0..DEPTH/4-1. It returns to IDLE after the last word, so `busy` is high for exactly DEPTH/4 cycles.
  - Core access while busy: reads return 0, writes are dropped, err code 3 is set, and nothing is counted.
- Counters: increment on each accepted access (reads where `bus_RE` is high, writes committed) and saturate at 16'hFFFF.
- Errors:
  - Only the first error is latched.
  - `err_clr` takes priority over a new error in the same cycle.
- The array is not reset. Memory contents survive `rst_n` assertion.

## Timing
- Read latency is 0 cycles, because the core samples `bus_in` on the same edge its strobe is high.
- Write latency is 1 edge: data is visible to a read in the next cycle.
- Reset values: `bus_in`=0, `ld_ready`=0 while in reset, `busy`=0, `rd_count`=0, `wr_count`=0, `err`=0, `err_code`=0, `err_addr`=0, FSM=IDLE.
- Reset asserted mid-CLEAR aborts the clear immediately. Words already zeroed stay zeroed.
- `busy` rises on the edge after `clr_start` and falls on the edge that writes the last word.

## Configuration
- `Y86_MEM_WRAP_EN` defined:
  - Every byte address is taken modulo DEPTH, so an access at DEPTH-2 spans bytes DEPTH-2, DEPTH-1, 0, 1.
  - Range error (code 1) never occurs.
- Not defined:
  - An access is out of range if `bus_A` + 3 ≥ DEPTH; this includes the upper bits of `bus_A` being non-zero.
  - Out-of-range reads return 0, out-of-range writes are dropped, and err code 1 is set.
  - Out-of-range accesses are not counted.

## Structure
- Package `y86_mem_pkg`: err_code enum (`ERR_NONE`, `ERR_RANGE`, `ERR_COLL`, `ERR_BUSY`), clear FSM state enum, and the counter width constant (16).
- Sub-module `y86_mem_clear_fsm`: state register, word index counter, `busy`, and the clear write enable and index. The top muxes core writes, preload and clear onto the byte array.

## Test plan
- Preload bytes 0..3 = 8B,45,01,89 and read `bus_A`=0 → `bus_in`=32'h8901458B. Read `bus_A`=1 → 32'hxx89_0145 (top byte = byte 4).
- Write `bus_A`=5, `bus_out`=32'hDEADBEEF, with a read at 5 in the same cycle → old data in that cycle, 32'hDEADBEEF next cycle; `wr_count`=1.
- `bus_RE` and `bus_WE` high at 8 → err=1, err_code=2, err_addr=8, write committed. Then `err_clr` → err=0.
- Without `Y86_MEM_WRAP_EN`, ADDR_W=12, read at 32'h0FFE → `bus_in`=0, err_code=1, `rd_count` unchanged. With the macro defined → bytes FFE, FFF, 000, 001.
- `clr_start` with ADDR_W=4 → `busy` high for 4 cycles, then all reads = 0. Read during busy → 0 and err_code=3. Reset in cycle 2 of the clear → `busy`=0 at once and word 3 unchanged.
- Issue 65540 reads → `rd_count` holds 16'hFFFF.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types and constants for the y86 bus memory
package y86_mem_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_COLL  = 2'd2,
    ERR_BUSY  = 2'd3
  } err_code_e;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/y86_mem_clear_fsm.sv
// rtl/y86_mem_clear_fsm.sv - whole-array clear sequencer, one aligned word per cycle
module y86_mem_clear_fsm
  import y86_mem_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr_start,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_idx
);

  clr_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_start) begin
          w_state_nxt = CLR_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLR_CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        // leave on the same edge that zeroes the last word
        if (r_idx == {IDX_W{1'b1}}) begin
          w_state_nxt = CLR_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_clr_idx = r_idx;

endmodule

// File: rtl/y86_bus_mem.sv
// rtl/y86_bus_mem.sv - zero-wait byte-addressed memory opposite the y86 core bus
// Optional address wrap-around: Y86_MEM_WRAP_EN
module y86_bus_mem
  import y86_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [31:0]       bus_out,
  output logic [31:0]       bus_in,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              clr_start,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [31:0]       err_addr,
  input  logic              err_clr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = ADDR_W - 2;

  logic [7:0]        r_mem [DEPTH];
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_idx;
  logic [ADDR_W-1:0] w_ba [4];
  logic              w_in_range, w_ok, w_rd_ok, w_wr_ok, w_ld_we;
  logic              w_err_ev;
  err_code_e         w_err_cause;
  logic              r_err;
  err_code_e         r_err_code;
  logic [31:0]       r_err_addr;
  logic [CNT_W-1:0]  r_rd_count, r_wr_count;

  y86_mem_clear_fsm #(.IDX_W(IDX_W)) u_clear (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr_start (clr_start),
    .o_busy      (busy),
    .o_clr_we    (w_clr_we),
    .o_clr_idx   (w_clr_idx)
  );

  // byte lanes truncate to ADDR_W, which is the wrap; the range check keeps it unused otherwise
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ba[k] = bus_A[ADDR_W-1:0] + k[ADDR_W-1:0];
    end
  end

`ifdef Y86_MEM_WRAP_EN
  assign w_in_range = 1'b1;
`else
  assign w_in_range = ({1'b0, bus_A} + 33'd3) < 33'(DEPTH);
`endif

  assign w_ok     = rst_n && !busy && w_in_range;
  assign w_rd_ok  = bus_RE && w_ok;
  assign w_wr_ok  = bus_WE && w_ok;
  assign ld_ready = rst_n && !busy && !bus_WE;
  assign w_ld_we  = ld_valid && ld_ready;

  assign bus_in = w_rd_ok ? {r_mem[w_ba[3]], r_mem[w_ba[2]], r_mem[w_ba[1]], r_mem[w_ba[0]]}
                          : 32'h0;

  // clear, core write and preload are mutually exclusive by construction
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      for (int k = 0; k < 4; k++) r_mem[{w_clr_idx, k[1:0]}] <= 8'h00;
    end else if (w_wr_ok) begin
      for (int k = 0; k < 4; k++) r_mem[w_ba[k]] <= bus_out[8*k +: 8];
    end else if (w_ld_we) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    w_err_ev    = 1'b0;
    w_err_cause = ERR_NONE;
    if (bus_RE || bus_WE) begin
      if (busy) begin
        w_err_ev    = 1'b1;
        w_err_cause = ERR_BUSY;
      end else if (!w_in_range) begin
        w_err_ev    = 1'b1;
        w_err_cause = ERR_RANGE;
      end else if (bus_RE && bus_WE) begin
        w_err_ev    = 1'b1;
        w_err_cause = ERR_COLL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_addr <= 32'h0;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_addr <= 32'h0;
    end else if (w_err_ev && !r_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_cause;
      r_err_addr <= bus_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_ok && (r_rd_count != {CNT_W{1'b1}})) r_rd_count <= r_rd_count + 1'b1;
      if (w_wr_ok && (r_wr_count != {CNT_W{1'b1}})) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_y86_bus_mem.sv
// tb/tb_y86_bus_mem.sv - scoreboard bench for y86_bus_mem
module tb_y86_bus_mem;
  localparam int AW    = 12;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   bus_A, bus_out, bus_in, err_addr;
  logic          bus_RE, bus_WE, ld_valid, ld_ready, clr_start, busy, err, err_clr;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [15:0]   rd_count, wr_count;
  logic [1:0]    err_code;

  y86_bus_mem #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
    .bus_out(bus_out), .bus_in(bus_in), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .clr_start(clr_start), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count), .err(err), .err_code(err_code),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_rd   = 0;
  int          exp_wr   = 0;
  logic [7:0]  m_mem [DEPTH];
  logic [31:0] exp_q [$];

  function automatic logic [AW-1:0] m_idx(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = (a + 32'(k)) & 32'(DEPTH - 1);
    return s[AW-1:0];
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[m_idx(a, k)];
    return w;
  endfunction

  function automatic bit m_in_range(input logic [31:0] a);
`ifdef Y86_MEM_WRAP_EN
    return 1'b1;
`else
    return a <= 32'(DEPTH - 4);
`endif
  endfunction

  task automatic idle_inputs();
    bus_A = 32'h0; bus_out = 32'h0; bus_RE = 1'b0; bus_WE = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = 8'h0; clr_start = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input string tag, output logic [31:0] got);
    logic [31:0] exp;
    @(negedge clk);
    bus_A = a; bus_RE = 1'b1; bus_WE = 1'b0;
    exp_q.push_back(m_in_range(a) ? m_word(a) : 32'h0);
    #1;
    exp = exp_q.pop_front();
    got = bus_in;
    n_checks++;
    if (bus_in !== exp) begin
      n_errors++;
      $display("FAIL read_%s: bus_in=%h expected %h", tag, bus_in, exp);
    end
    @(posedge clk);
    if (m_in_range(a) && exp_rd < 65535) exp_rd++;
    #1;
    bus_RE = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic re, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    bus_A = a; bus_out = d; bus_WE = 1'b1; bus_RE = re;
    if (re) begin
      exp_q.push_back(m_in_range(a) ? m_word(a) : 32'h0);
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus_in !== exp) begin
        n_errors++;
        $display("FAIL wr_old_%s: bus_in=%h expected %h", tag, bus_in, exp);
      end
    end
    @(posedge clk);
    if (m_in_range(a)) begin
      for (int k = 0; k < 4; k++) m_mem[m_idx(a, k)] = d[8*k +: 8];
      exp_wr++;
      if (re) exp_rd++;
    end
    #1;
    bus_WE = 1'b0; bus_RE = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ld_ready: got %b expected 1", ld_ready);
    end
    @(posedge clk);
    m_mem[a] = d;
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic do_err_clr(input string tag);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_checks++;
    if ({err, err_code, err_addr} !== 35'h0) begin
      n_errors++;
      $display("FAIL err_clr_%s: err=%b code=%0d addr=%h expected all 0", tag, err, err_code, err_addr);
    end
  endtask

  task automatic check_err(input logic [1:0] code, input logic [31:0] a, input string tag);
    n_checks++;
    if (err !== 1'b1 || err_code !== code || err_addr !== a) begin
      n_errors++;
      $display("FAIL err_%s: err=%b code=%0d addr=%h expected 1/%0d/%h", tag, err, err_code, err_addr, code, a);
    end
  endtask

  task automatic check_counts(input string tag);
    n_checks++;
    if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
      n_errors++;
      $display("FAIL counts_%s: rd=%0d wr=%0d expected rd=%0d wr=%0d", tag, rd_count, wr_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus_RE = 1'b1; ld_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_in, ld_ready, busy, rd_count, wr_count, err, err_code, err_addr} !== 100'h0) begin
      n_errors++;
      $display("FAIL reset: bus_in=%h ld_ready=%b busy=%b rd=%0d wr=%0d err=%b code=%0d addr=%h expected all 0",
               bus_in, ld_ready, busy, rd_count, wr_count, err, err_code, err_addr);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_clear();
    logic [31:0] got;
    int cyc;
    for (int i = 0; i < 4; i++) do_load(AW'(i), 8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) do_load(AW'(DEPTH - 4 + i), 8'hC0 + 8'(i));
    @(negedge clk);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_busy_rise: busy=%b expected 1", busy);
    end
    cyc = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      clr_start = (cyc == 20);
      if (cyc == 10) begin
        bus_A = 32'h0; bus_RE = 1'b1;
        #1;
        n_checks++;
        if (bus_in !== 32'h0 || ld_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_read: bus_in=%h ld_ready=%b expected 0/0", bus_in, ld_ready);
        end
      end
      @(posedge clk);
      #1;
      if (cyc == 10) begin
        bus_RE = 1'b0;
        check_err(2'd3, 32'h0, "busy");
      end
      if (!busy) break;
      cyc++;
    end
    clr_start = 1'b0;
    n_checks++;
    if (cyc !== DEPTH / 4) begin
      n_errors++;
      $display("FAIL clr_busy_len: busy cycles=%0d expected %0d", cyc, DEPTH / 4);
    end
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h0;
    check_counts("after_clear");
    do_err_clr("busy");
    do_read(32'h0, "clr_lo", got);
    do_read(32'(DEPTH - 4), "clr_hi", got);
    do_read(32'd2000, "clr_mid", got);
  endtask

  task automatic test_preload();
    logic [31:0] got;
    do_load(AW'(0), 8'h8B);
    do_load(AW'(1), 8'h45);
    do_load(AW'(2), 8'h01);
    do_load(AW'(3), 8'h89);
    do_load(AW'(4), 8'h77);
    do_read(32'h0, "pl0", got);
    n_checks++;
    if (got !== 32'h8901458B) begin
      n_errors++;
      $display("FAIL preload_a0: bus_in=%h expected 8901458b", got);
    end
    do_read(32'h1, "pl1", got);
    n_checks++;
    if (got !== 32'h77890145) begin
      n_errors++;
      $display("FAIL preload_a1: bus_in=%h expected 77890145", got);
    end
    check_counts("preload");
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    do_load(AW'(5), 8'h12);
    do_load(AW'(6), 8'h34);
    do_write(32'd5, 32'hDEADBEEF, 1'b1, "a5");
    do_read(32'd5, "a5_new", got);
    n_checks++;
    if (got !== 32'hDEADBEEF || wr_count !== 16'd1) begin
      n_errors++;
      $display("FAIL write_a5: bus_in=%h wr_count=%0d expected deadbeef/1", got, wr_count);
    end
    check_err(2'd2, 32'd5, "coll_a5");
    do_err_clr("a5");
    check_counts("write");
  endtask

  task automatic test_collision();
    logic [31:0] got;
    do_write(32'd8, 32'hCAFEF00D, 1'b1, "a8");
    check_err(2'd2, 32'd8, "coll_a8");
    do_read(32'd8, "a8_new", got);
    do_err_clr("a8");
    do_write(32'd20, 32'h01020304, 1'b1, "a20");
    do_write(32'd24, 32'h05060708, 1'b1, "a24");
    check_err(2'd2, 32'd20, "first_only");
    @(negedge clk);
    err_clr = 1'b1;
    bus_A = 32'd16; bus_out = 32'hA5A5A5A5; bus_RE = 1'b1; bus_WE = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) m_mem[16 + k] = 8'hA5;
    exp_rd++; exp_wr++;
    #1;
    err_clr = 1'b0; bus_RE = 1'b0; bus_WE = 1'b0;
    n_checks++;
    if (err !== 1'b0 || err_code !== 2'd0) begin
      n_errors++;
      $display("FAIL clr_priority: err=%b code=%0d expected 0/0", err, err_code);
    end
    do_read(32'd16, "a16", got);
    check_counts("collision");
  endtask

  task automatic test_range();
    logic [31:0] got;
    do_load(AW'(DEPTH - 2), 8'hAA);
    do_load(AW'(DEPTH - 1), 8'hBB);
    do_read(32'h0FFE, "ffe", got);
`ifdef Y86_MEM_WRAP_EN
    n_checks++;
    if (got !== 32'h458BBBAA || err !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_ffe: bus_in=%h err=%b expected 458bbbaa/0", got, err);
    end
`else
    n_checks++;
    if (got !== 32'h0) begin
      n_errors++;
      $display("FAIL range_ffe: bus_in=%h expected 0", got);
    end
    check_err(2'd1, 32'h0FFE, "range");
`endif
    check_counts("range_rd");
    do_read(32'h0FFC, "ffc", got);
    do_write(32'h0FFD, 32'h12345678, 1'b0, "ffd");
    do_read(32'h0FFC, "ffc_after", got);
    do_read(32'h1000_0000, "hi_bits", got);
    check_counts("range");
    do_err_clr("range");
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] got;
    for (int i = 0; i < 8; i++) do_load(AW'(i), 8'h01 + 8'(i));
    for (int i = 0; i < 4; i++) do_load(AW'(12 + i), 8'hA1 + 8'(i));
    @(negedge clk);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_busy: busy=%b expected 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h0;
    do_read(32'd0, "abort_w0", got);
    do_read(32'd4, "abort_w1", got);
    do_read(32'd12, "abort_w3", got);
    n_checks++;
    if (got !== 32'hA4A3A2A1) begin
      n_errors++;
      $display("FAIL abort_w3_const: bus_in=%h expected a4a3a2a1", got);
    end
    check_counts("abort");
  endtask

  task automatic test_saturate();
    int pre;
    pre = 65534 - exp_rd;
    @(negedge clk);
    bus_A = 32'd0; bus_RE = 1'b1;
    repeat (pre) @(posedge clk);
    #1;
    n_checks++;
    if (rd_count !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sat_pre: rd_count=%h expected fffe", rd_count);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_count !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL sat_hit: rd_count=%h expected ffff", rd_count);
    end
    repeat (5) @(posedge clk);
    #1;
    bus_RE = 1'b0;
    n_checks++;
    if (rd_count !== 16'hFFFF || wr_count !== 16'(exp_wr)) begin
      n_errors++;
      $display("FAIL sat_hold: rd_count=%h wr_count=%0d expected ffff/%0d", rd_count, wr_count, exp_wr);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clear();
    test_preload();
    test_write_read();
    test_collision();
    test_range();
    test_reset_mid_clear();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
